// File: rtl/fdiv_core_pkg.sv
// Single-precision field layout and helpers shared by the divider core and its bench.
// Only normal numbers are represented; denormals collapse to zero.
package fpu_pkg;
  localparam int BIAS = 127;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam logic [EXP_W-1:0] EXP_RECIP126 = 8'd253;

  typedef struct packed {
    logic             s;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
  } fp32_t;

  function automatic logic f_sign(input logic [31:0] x);
    return x[31];
  endfunction

  function automatic logic [EXP_W-1:0] f_exp(input logic [31:0] x);
    return x[30:23];
  endfunction

  function automatic logic [MAN_W-1:0] f_man(input logic [31:0] x);
    return x[22:0];
  endfunction
endpackage

// File: rtl/fdiv_core_if.sv
// Dispatch, reciprocal-unit and writeback signals of the divider; slave is the core side.
interface fdiv_core_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] recip_b;
  logic [31:0] recip_q;
  logic        recip_flag126;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_q;

  modport slave (
    input  in_valid, in_a, in_b, recip_q, recip_flag126, out_ready,
    output in_ready, recip_b, out_valid, out_q
  );

  modport master (
    output in_valid, in_a, in_b, recip_q, recip_flag126, out_ready,
    input  in_ready, recip_b, out_valid, out_q
  );
endinterface

// File: rtl/fdiv_out_fifo.sv
// Synchronous result FIFO; pointers wrap modulo DEPTH so any depth >= 1 works.
// Simultaneous push and pop leave the count unchanged; a pop on empty is ignored.
module fdiv_out_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic [CW-1:0]    count,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop_ok) rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop_ok)      count <= count + 1'b1;
      else if (!push && pop_ok) count <= count - 1'b1;
    end
  end

  // Upstream credits guarantee room; a push into a full FIFO means the credit math broke.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop_ok && (count == CW'(DEPTH))));
endmodule

// File: rtl/fdiv_core.sv
// Pipelined q = a * (1/b): S0 -> reciprocal delay line -> M1 multiply -> M2 normalise -> FIFO.
// Accept-to-out_valid is RECIP_LAT+3 edges; in_ready is a credit check over stages plus FIFO.
module fdiv_core import fpu_pkg::*; #(
  parameter int RECIP_LAT  = 2,
  parameter int FIFO_DEPTH = 8
) (
  input logic       clk,
  input logic       rst,
  fdiv_core_if.slave io
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic                 s0_v;
  logic [31:0]          s0_a;
  logic [31:0]          s0_b;
  logic [RECIP_LAT-1:0] d_v;
  logic [31:0]          d_a [RECIP_LAT];
  logic                 m1_v;
  logic                 m1_s;
  logic                 m1_z;
  logic signed [9:0]    m1_e;
  logic [47:0]          m1_p;
  logic                 m2_v;
  logic [31:0]          m2_q;

  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic [31:0]   fifo_head;
  logic          in_rdy;
  logic          accept;
  logic [31:0]   a_d;
  logic [47:0]   ma;
  logic [47:0]   mb;
  logic signed [9:0] e_n;
  logic [22:0]   man_n;
  fp32_t         res;
  logic          unused_p_lo;

  // Credits count every valid stage, so the FIFO always has a slot when M2 pushes.
  assign in_rdy = ($countones({s0_v, d_v, m1_v, m2_v}) + int'(fifo_count)) < FIFO_DEPTH;
  assign accept = io.in_valid && in_rdy;
  assign a_d    = d_a[RECIP_LAT-1];
  assign ma     = {24'd0, 1'b1, f_man(a_d)};
  assign mb     = {24'd0, 1'b1, f_man(io.recip_q)};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_v <= 1'b0;
      s0_a <= '0;
      s0_b <= '0;
      d_v  <= '0;
      for (int i = 0; i < RECIP_LAT; i++) d_a[i] <= '0;
      m1_v <= 1'b0;
      m1_s <= 1'b0;
      m1_z <= 1'b0;
      m1_e <= '0;
      m1_p <= '0;
      m2_v <= 1'b0;
      m2_q <= '0;
    end else begin
      s0_v <= accept;
      if (accept) begin
        s0_a <= io.in_a;
        s0_b <= io.in_b;
      end
      d_v[0] <= s0_v;
      d_a[0] <= s0_a;
      for (int i = 1; i < RECIP_LAT; i++) begin
        d_v[i] <= d_v[i-1];
        d_a[i] <= d_a[i-1];
      end
      // The reciprocal unit never stalls; its output is only meaningful when d_v says so.
      m1_v <= d_v[RECIP_LAT-1];
      m1_s <= f_sign(a_d) ^ f_sign(io.recip_q);
      m1_e <= {2'b00, f_exp(a_d)} + {2'b00, f_exp(io.recip_q)} - 10'(BIAS)
              - {9'd0, io.recip_flag126};
      m1_p <= ma * mb;
      m1_z <= (f_exp(a_d) == '0) || ((f_exp(io.recip_q) == '0) && !io.recip_flag126);
      m2_v <= m1_v;
      m2_q <= res;
    end
  end

  always_comb begin
    e_n   = m1_p[47] ? m1_e + 10'sd1 : m1_e;
    man_n = m1_p[47] ? m1_p[46:24] : m1_p[45:23];
    res   = '{s: m1_s, e: e_n[7:0], m: man_n};
    if (m1_z || (e_n <= 10'sd0)) res = '{s: m1_s, e: 8'h00, m: 23'd0};
    else if (e_n >= 10'sd255)    res = '{s: m1_s, e: 8'hFF, m: 23'd0};
  end

  // Low product bits fall below the truncation point.
  assign unused_p_lo = ^m1_p[22:0];

  fdiv_out_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (m2_v),
    .push_dat (m2_q),
    .pop      (io.out_ready),
    .pop_dat  (fifo_head),
    .count    (fifo_count),
    .empty    (fifo_empty)
  );

  assign io.in_ready  = in_rdy;
  assign io.recip_b   = s0_b;
  assign io.out_valid = !fifo_empty;
  assign io.out_q     = fifo_head;
endmodule

// File: tb/tb_fdiv_core.sv
// Bench for fdiv_core with a 2-stage rounded reciprocal model and a scoreboard of expected quotients.
module tb_fdiv_core;
  import fpu_pkg::*;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    bit          exact;
  } vec_t;

  typedef struct {
    logic [31:0] q;
    bit          exact;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  fdiv_core_if dif();

  fdiv_core #(.RECIP_LAT(2), .FIFO_DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .io  (dif.slave)
  );

  always #5 clk = ~clk;

  // Reciprocal unit: mantissa 2/(1.m) rounded, exponent 253-e; e=253 reports exponent 1 plus flag.
  function automatic logic [32:0] recip_model(input logic [31:0] b);
    logic [7:0] eb;
    int e;
    int m;
    real r;
    eb = b[30:23];
    if (eb == 8'd0) return {1'b0, b[31], 8'hFF, 23'd0};
    e = 253 - int'(eb);
    r = 2.0 / (1.0 + real'(b[22:0]) / 8388608.0);
    m = $rtoi(r * 8388608.0 + 0.5);
    if (m > 16777215) m = 16777215;
    if (eb == EXP_RECIP126) return {1'b1, b[31], 8'd1, m[22:0]};
    if (e < 0) return {1'b0, b[31], 8'd0, 23'd0};
    return {1'b0, b[31], e[7:0], m[22:0]};
  endfunction

  logic [32:0] rstage1;
  logic [32:0] rstage2;
  always @(posedge clk) begin
    rstage1 <= recip_model(dif.recip_b);
    rstage2 <= rstage1;
  end
  assign dif.recip_q       = rstage2[31:0];
  assign dif.recip_flag126 = rstage2[32];

  function automatic real f2r(input logic [31:0] x);
    logic [63:0] d;
    d = {x[31], 11'(int'(x[30:23]) + 896), x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real v);
    logic [63:0] d;
    int e;
    logic [23:0] m;
    d = $realtobits(v);
    e = int'(d[62:52]) - 896;
    m = {1'b0, d[51:29]} + {23'd0, d[28]};
    if (m[23]) begin
      e = e + 1;
      m = 24'd0;
    end
    return {d[63], e[7:0], m[22:0]};
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    v.a = {1'($urandom_range(0, 1)), 8'($urandom_range(154, 100)), 23'($urandom)};
    v.b = {1'($urandom_range(0, 1)), 8'($urandom_range(154, 100)), 23'($urandom)};
    v.q = r2f(f2r(v.a) / f2r(v.b));
    v.exact = 1'b0;
    return v;
  endfunction

  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_pop = 0;
  int   tp_gaps = 0;
  bit   tp_mon = 1'b0;
  bit   last_acc;
  exp_t cur_exp;
  exp_t sb[$];
  vec_t tbl[8];

  task automatic chk(input string nm, input bit ok, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, req);
    end
  endtask

  function automatic bit close(input logic [31:0] act, input logic [31:0] req, input bit exact);
    int da;
    if (exact) return act == req;
    da = int'({1'b0, act[30:0]}) - int'({1'b0, req[30:0]});
    return (act[31] == req[31]) && (da >= -2) && (da <= 2);
  endfunction

  task automatic drive(input vec_t v);
    dif.in_valid = 1'b1;
    dif.in_a = v.a;
    dif.in_b = v.b;
    cur_exp = '{q: v.q, exact: v.exact};
  endtask

  // One clock: handshakes are sampled from settled pre-edge values, checked after the edge.
  task automatic step();
    bit acc;
    bit pop;
    logic [31:0] head;
    exp_t e;
    acc  = dif.in_valid && dif.in_ready;
    pop  = dif.out_valid && dif.out_ready;
    head = dif.out_q;
    if (tp_mon && dif.out_ready && !dif.out_valid) tp_gaps++;
    @(posedge clk);
    #1;
    last_acc = acc;
    if (acc) sb.push_back(cur_exp);
    if (pop) begin
      n_pop++;
      chk("spurious_out", sb.size() != 0, head, 32'd0);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("result", close(head, e.q, e.exact), head, e.q);
      end
    end
  endtask

  task automatic drain(input string nm);
    int c = 0;
    dif.in_valid = 1'b0;
    dif.out_ready = 1'b1;
    while (sb.size() > 0 && c < 100) begin
      step();
      c++;
    end
    chk(nm, sb.size() == 0, 32'(sb.size()), 32'd0);
  endtask

  task automatic latency_check(input vec_t v, input string nm);
    int cyc = 0;
    dif.out_ready = 1'b0;
    drive(v);
    step();
    dif.in_valid = 1'b0;
    while (!dif.out_valid && cyc < 20) begin
      step();
      cyc++;
    end
    chk(nm, cyc == 5, 32'(cyc), 32'd5);
    dif.out_ready = 1'b1;
    step();
    dif.out_ready = 1'b0;
  endtask

  initial begin
    vec_t v;
    int acc_cnt;
    int cyc;
    int pop0;

    tbl[0] = '{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0};
    tbl[1] = '{32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0};
    tbl[2] = '{32'h00000000, 32'h40000000, 32'h00000000, 1'b1};
    tbl[3] = '{32'h7F000000, 32'h7E800000, 32'h40000000, 1'b0};
    tbl[4] = '{32'h7F7FFFFF, 32'h00800000, 32'h7F800000, 1'b1};
    tbl[5] = '{32'h00800000, 32'h7F000000, 32'h00000000, 1'b1};
    tbl[6] = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0};
    tbl[7] = '{32'hBF800000, 32'hC0800000, 32'h3E800000, 1'b0};

    rst = 1'b1;
    dif.in_valid = 1'b0;
    dif.in_a = '0;
    dif.in_b = '0;
    dif.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", dif.in_ready == 1'b1, 32'(dif.in_ready), 32'd1);
    chk("rst_out_valid", dif.out_valid == 1'b0, 32'(dif.out_valid), 32'd0);
    chk("rst_out_q", dif.out_q == 32'd0, dif.out_q, 32'd0);
    chk("rst_recip_b", dif.recip_b == 32'd0, dif.recip_b, 32'd0);
    rst = 1'b0;
    step();

    latency_check(tbl[0], "latency_first");

    // Table vectors streamed back to back.
    dif.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i]);
      cyc = 0;
      step();
      while (!last_acc && cyc < 20) begin
        step();
        cyc++;
      end
    end
    drain("table_drain");

    // Backpressure: credits must stop acceptance at the FIFO depth.
    dif.out_ready = 1'b0;
    acc_cnt = 0;
    v = rand_vec();
    for (int c = 0; c < 20; c++) begin
      drive(v);
      step();
      if (last_acc) begin
        acc_cnt++;
        v = rand_vec();
      end
    end
    chk("bp_accepts", acc_cnt == 8, 32'(acc_cnt), 32'd8);
    chk("bp_in_ready_low", dif.in_ready == 1'b0, 32'(dif.in_ready), 32'd0);
    pop0 = n_pop;
    drain("bp_drain");
    chk("bp_pops", (n_pop - pop0) == 8, 32'(n_pop - pop0), 32'd8);
    chk("bp_resume", dif.in_ready == 1'b1, 32'(dif.in_ready), 32'd1);

    // Random streaming with random consumer stalls.
    acc_cnt = 0;
    cyc = 0;
    v = rand_vec();
    while (acc_cnt < 1000 && cyc < 20000) begin
      dif.out_ready = 1'($urandom_range(0, 1));
      drive(v);
      step();
      if (last_acc) begin
        acc_cnt++;
        v = rand_vec();
      end
      cyc++;
    end
    chk("stream_accepts", acc_cnt == 1000, 32'(acc_cnt), 32'd1000);

    // Steady state with the consumer always ready: one result per cycle.
    dif.out_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (c == 20) tp_mon = 1'b1;
      drive(v);
      step();
      if (last_acc) v = rand_vec();
    end
    tp_mon = 1'b0;
    chk("throughput_gaps", tp_gaps == 0, 32'(tp_gaps), 32'd0);
    drain("stream_drain");

    // Reset with 3 results in flight and 2 buffered.
    dif.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      drive(rand_vec());
      step();
    end
    dif.in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    rst = 1'b0;
    chk("rstmid_out_valid", dif.out_valid == 1'b0, 32'(dif.out_valid), 32'd0);
    chk("rstmid_in_ready", dif.in_ready == 1'b1, 32'(dif.in_ready), 32'd1);
    pop0 = n_pop;
    dif.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) step();
    chk("rstmid_no_output", n_pop == pop0, 32'(n_pop - pop0), 32'd0);
    latency_check(tbl[6], "latency_after_rst");
    drain("final_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
